// File: rtl/msdft_ctrl_axil_slave.sv
// AXI4-Lite register file for the MSDFT core: four RW control words, a RO
// status word, a self-clearing START strobe, and an unmapped tail that answers
// with SLVERR. Independent write (W_IDLE/W_RESP) and read (R_IDLE/R_DATA) FSMs,
// one clock domain, synchronous active-low reset.
`timescale 1ns/1ps
module msdft_ctrl_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
  input  logic [2:0]                        s00_axi_awprot,
  input  logic                              s00_axi_awvalid,
  output logic                              s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
  input  logic                              s00_axi_wvalid,
  output logic                              s00_axi_wready,
  output logic [1:0]                        s00_axi_bresp,
  output logic                              s00_axi_bvalid,
  input  logic                              s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
  input  logic [2:0]                        s00_axi_arprot,
  input  logic                              s00_axi_arvalid,
  output logic                              s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
  output logic [1:0]                        s00_axi_rresp,
  output logic                              s00_axi_rvalid,
  input  logic                              s00_axi_rready,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0]   ctrl_regs,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     status_in,
  output logic                              start_pulse
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = C_S_AXI_DATA_WIDTH / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [2:0] IDX_STATUS = 3'd4;
  localparam logic [2:0] IDX_START  = 3'd5;

  typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_e;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

  // Byte-lane merge: lanes with their strobe set take the new byte.
  function automatic logic [DW-1:0] apply_strb(input logic [DW-1:0] old_v,
                                               input logic [DW-1:0] new_v,
                                               input logic [SW-1:0] strb);
    logic [DW-1:0] res;
    res = old_v;
    for (int b = 0; b < SW; b++) begin
      if (strb[b]) begin
        res[8*b +: 8] = new_v[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_v[8*b +: 8];
      end
    end
    return res;
  endfunction

  // Protection bits and the byte offset carry no meaning for this map.
  logic unused_s;
  assign unused_s = ^{s00_axi_awprot, s00_axi_arprot,
                      s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  // ---------------- write side state ----------------
  w_state_e        w_state_q, w_state_d;
  logic            aw_got_q, aw_got_d;
  logic [2:0]      awidx_q, awidx_d;
  logic            w_got_q, w_got_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [SW-1:0]   wstrb_q, wstrb_d;
  logic            awready_q, awready_d;
  logic            wready_q, wready_d;
  logic            bvalid_q, bvalid_d;
  logic [1:0]      bresp_q, bresp_d;
  logic            start_q, start_d;
  logic [DW-1:0]   ctrl_q [4];
  logic [DW-1:0]   ctrl_d [4];

  logic            aw_hs_s, w_hs_s;
  logic [2:0]      cmt_idx_s;
  logic [DW-1:0]   cmt_data_s;
  logic [SW-1:0]   cmt_strb_s;

  // ---------------- read side state ----------------
  r_state_e        r_state_q, r_state_d;
  logic            arready_q, arready_d;
  logic            rvalid_q, rvalid_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [1:0]      rresp_q, rresp_d;
  logic            ar_hs_s;

  // Write FSM: capture AW and W independently, commit when both are held.
  always_comb begin
    w_state_d  = w_state_q;
    aw_got_d   = aw_got_q;
    awidx_d    = awidx_q;
    w_got_d    = w_got_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    awready_d  = awready_q;
    wready_d   = wready_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    start_d    = 1'b0;
    ctrl_d     = ctrl_q;
    aw_hs_s    = s00_axi_awvalid & awready_q;
    w_hs_s     = s00_axi_wvalid & wready_q;
    cmt_idx_s  = aw_hs_s ? s00_axi_awaddr[4:2] : awidx_q;
    cmt_data_s = w_hs_s ? s00_axi_wdata : wdata_q;
    cmt_strb_s = w_hs_s ? s00_axi_wstrb : wstrb_q;
    case (w_state_q)
      W_IDLE: begin
        if ((aw_hs_s | aw_got_q) && (w_hs_s | w_got_q)) begin
          w_state_d = W_RESP;
          aw_got_d  = 1'b0;
          w_got_d   = 1'b0;
          awready_d = 1'b0;
          wready_d  = 1'b0;
          bvalid_d  = 1'b1;
          case (cmt_idx_s)
            3'd0, 3'd1, 3'd2, 3'd3: begin
              ctrl_d[cmt_idx_s[1:0]] = apply_strb(ctrl_q[cmt_idx_s[1:0]], cmt_data_s, cmt_strb_s);
              bresp_d = RESP_OKAY;
            end
            IDX_START: begin
              start_d = cmt_data_s[0] & cmt_strb_s[0];
              bresp_d = RESP_OKAY;
            end
            default: begin
              // STATUS is read-only and 0x18/0x1C are unmapped.
              bresp_d = RESP_SLVERR;
            end
          endcase
        end else begin
          if (aw_hs_s) begin
            aw_got_d  = 1'b1;
            awidx_d   = s00_axi_awaddr[4:2];
            awready_d = 1'b0;
          end else begin
            awready_d = ~aw_got_q;
          end
          if (w_hs_s) begin
            w_got_d  = 1'b1;
            wdata_d  = s00_axi_wdata;
            wstrb_d  = s00_axi_wstrb;
            wready_d = 1'b0;
          end else begin
            wready_d = ~w_got_q;
          end
        end
      end
      W_RESP: begin
        if (s00_axi_bready) begin
          w_state_d = W_IDLE;
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
        end else begin
          w_state_d = W_RESP;
        end
      end
      default: begin
        w_state_d = W_IDLE;
      end
    endcase
  end

  // Write-side registers, including the control words themselves.
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      w_state_q <= W_IDLE;
      aw_got_q  <= 1'b0;
      awidx_q   <= 3'd0;
      w_got_q   <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      start_q   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        ctrl_q[i] <= '0;
      end
    end else begin
      w_state_q <= w_state_d;
      aw_got_q  <= aw_got_d;
      awidx_q   <= awidx_d;
      w_got_q   <= w_got_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      start_q   <= start_d;
      for (int i = 0; i < 4; i++) begin
        ctrl_q[i] <= ctrl_d[i];
      end
    end
  end

  // Read FSM: register data from the pre-edge register contents on AR handshake.
  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    ar_hs_s   = s00_axi_arvalid & arready_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs_s) begin
          r_state_d = R_DATA;
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          case (s00_axi_araddr[4:2])
            3'd0, 3'd1, 3'd2, 3'd3: begin
              rdata_d = ctrl_q[s00_axi_araddr[3:2]];
              rresp_d = RESP_OKAY;
            end
            IDX_STATUS: begin
              rdata_d = status_in;
              rresp_d = RESP_OKAY;
            end
            IDX_START: begin
              rdata_d = '0;
              rresp_d = RESP_OKAY;
            end
            default: begin
              rdata_d = '0;
              rresp_d = RESP_SLVERR;
            end
          endcase
        end else begin
          arready_d = 1'b1;
        end
      end
      R_DATA: begin
        if (s00_axi_rready) begin
          r_state_d = R_IDLE;
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
        end else begin
          r_state_d = R_DATA;
        end
      end
      default: begin
        r_state_d = R_IDLE;
      end
    endcase
  end

  // Read-side registers.
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign s00_axi_awready = awready_q;
  assign s00_axi_wready  = wready_q;
  assign s00_axi_bvalid  = bvalid_q;
  assign s00_axi_bresp   = bresp_q;
  assign s00_axi_arready = arready_q;
  assign s00_axi_rvalid  = rvalid_q;
  assign s00_axi_rdata   = rdata_q;
  assign s00_axi_rresp   = rresp_q;
  assign start_pulse     = start_q;
  assign ctrl_regs       = {ctrl_q[3], ctrl_q[2], ctrl_q[1], ctrl_q[0]};

endmodule
